// File: rtl/fc_pe_row_acc.sv
// 1xN_PE output-stationary MAC row for a fully-connected layer.
// Accumulates a streamed ifmap vector against per-PE weights, then drains requantised results serially.
module fc_pe_row_acc #(
    parameter int N_PE   = 128,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [LEN_W-1:0]           cfg_len_i,
    input  logic [4:0]                 cfg_shift_i,
    input  logic                       cfg_relu_i,
    output logic                       busy_o,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic signed [DATA_W-1:0]   ifmap_i,
    input  logic [N_PE*DATA_W-1:0]     weight_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [DATA_W-1:0]   out_data_o,
    output logic [$clog2(N_PE)-1:0]    out_idx_o,
    output logic                       done_o
);

    localparam int IDX_W = $clog2(N_PE);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [LEN_W-1:0]         len_q, elem_cnt;
    logic [4:0]               shift_q;
    logic                     relu_q;
    logic [IDX_W-1:0]         idx;
    logic                     done_q;
    logic signed [ACC_W-1:0]  acc [N_PE];

    logic in_hs, out_hs, last_in, last_out, start_acc;

    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    // ReLU, round-half-up arithmetic shift one bit wider than acc, then clamp to DATA_W
    function automatic logic signed [DATA_W-1:0] requant(
        input logic signed [ACC_W-1:0] a,
        input logic                    relu,
        input logic [4:0]              sh
    );
        logic signed [ACC_W:0] r;
        logic signed [ACC_W:0] bias;
        r = (relu && a < 0) ? '0 : {a[ACC_W-1], a};
        if (sh != 5'd0) begin
            bias    = '0;
            bias[0] = 1'b1;
            bias    = bias << (sh - 5'd1);
            r       = (r + bias) >>> sh;
        end
        if (r > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
        else if (r < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        else                  return r[DATA_W-1:0];
    endfunction

    assign in_ready_o  = (state == ACC) && (len_q != '0);
    assign out_valid_o = (state == DRAIN);
    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;
    assign out_idx_o   = idx;
    assign out_data_o  = (state == DRAIN) ? requant(acc[idx], relu_q, shift_q) : '0;

    assign start_acc = (state == IDLE) && start_i;
    assign in_hs     = in_valid_i && in_ready_o;
    assign out_hs    = out_valid_o && out_ready_i;
    assign last_in   = (elem_cnt + LEN_W'(1)) == len_q;
    assign last_out  = (idx == IDX_W'(N_PE-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = ACC;
            ACC:     if (len_q == '0 || (in_hs && last_in)) state_nxt = DRAIN;
            DRAIN:   if (out_hs && last_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage: config latch and MAC accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            elem_cnt <= '0;
            for (int i = 0; i < N_PE; i++) acc[i] <= '0;
        end else if (start_acc) begin
            len_q    <= cfg_len_i;
            shift_q  <= cfg_shift_i;
            relu_q   <= cfg_relu_i;
            elem_cnt <= '0;
            for (int i = 0; i < N_PE; i++) acc[i] <= '0;
        end else if (in_hs) begin
            elem_cnt <= elem_cnt + LEN_W'(1);
            for (int i = 0; i < N_PE; i++)
                acc[i] <= acc[i] + mac_term(ifmap_i, weight_i[i*DATA_W +: DATA_W]);
        end
    end

    // Stage: serial drain index and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= out_hs && last_out;
            if (out_hs) idx <= last_out ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_fc_pe_row_acc.sv
// Scoreboard bench for fc_pe_row_acc with N_PE=4: directed vectors, decoupled output monitor.
module tb_fc_pe_row_acc;

    localparam int N_PE = 4, DATA_W = 8, ACC_W = 24, LEN_W = 16;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start_i = 1'b0;
    logic [LEN_W-1:0]          cfg_len_i = '0;
    logic [4:0]                cfg_shift_i = '0;
    logic                      cfg_relu_i = 1'b0;
    logic                      busy_o;
    logic                      in_valid_i = 1'b0;
    logic                      in_ready_o;
    logic signed [DATA_W-1:0]  ifmap_i = '0;
    logic [N_PE*DATA_W-1:0]    weight_i = '0;
    logic                      out_valid_o;
    logic                      out_ready_i = 1'b1;
    logic signed [DATA_W-1:0]  out_data_o;
    logic [1:0]                out_idx_o;
    logic                      done_o;

    fc_pe_row_acc #(.N_PE(N_PE), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_len_i(cfg_len_i),
        .cfg_shift_i(cfg_shift_i), .cfg_relu_i(cfg_relu_i), .busy_o(busy_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .ifmap_i(ifmap_i),
        .weight_i(weight_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_idx_o(out_idx_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int data; } exp_t;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   exp_done = 1'b0;
    bit   rdy_toggle = 1'b0;

    logic signed [DATA_W-1:0] xs [8];
    logic [N_PE*DATA_W-1:0]   ws [8];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N_PE*DATA_W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [7:0] a8, b8, c8, d8;
        a8 = 8'(a); b8 = 8'(b); c8 = 8'(c); d8 = 8'(d);
        return {d8, c8, b8, a8};
    endfunction

    task automatic expect4(input int a, input int b, input int c, input int d);
        exp_t e;
        e.idx = 0; e.data = a; q.push_back(e);
        e.idx = 1; e.data = b; q.push_back(e);
        e.idx = 2; e.data = c; q.push_back(e);
        e.idx = 3; e.data = d; q.push_back(e);
    endtask

    // Ready driver: constant 1, or 1010... alternating when toggling
    initial forever begin
        @(posedge clk); #1;
        out_ready_i = rdy_toggle ? ~out_ready_i : 1'b1;
    end

    // Monitor: pops scoreboard on each output handshake, checks hold under stall and done pulse
    initial begin
        bit stall_prev = 1'b0;
        int prev_data = 0, prev_idx = 0;
        forever begin
            @(negedge clk);
            if (exp_done) begin
                chk("done_pulse", int'(done_o), 1);
                exp_done = 1'b0;
            end else if (done_o) begin
                chk("done_spurious", 1, 0);
            end
            if (stall_prev && out_valid_o) begin
                chk("stall_data_hold", int'(out_data_o), prev_data);
                chk("stall_idx_hold", int'(out_idx_o), prev_idx);
            end
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", int'(out_data_o), -999);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_idx", int'(out_idx_o), e.idx);
                    chk("out_data", int'(out_data_o), e.data);
                    if (e.idx == N_PE-1) exp_done = 1'b1;
                end
            end
            stall_prev = out_valid_o && !out_ready_i;
            prev_data  = int'(out_data_o);
            prev_idx   = int'(out_idx_o);
        end
    end

    task automatic do_start(input int len, input int sh, input bit relu, input bit hold);
        start_i     = 1'b1;
        cfg_len_i   = LEN_W'(len);
        cfg_shift_i = 5'(sh);
        cfg_relu_i  = relu;
        @(posedge clk); #1;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic feed(input int len, input bit gap);
        for (int k = 0; k < len; k++) begin
            bit hs;
            int tmo;
            hs = 1'b0;
            tmo = 0;
            ifmap_i = xs[k]; weight_i = ws[k]; in_valid_i = 1'b1;
            while (!hs) begin
                @(negedge clk);
                hs = in_ready_o;
                @(posedge clk); #1;
                tmo++;
                if (tmo > 50) begin
                    chk("in_handshake_timeout", 0, 1);
                    in_valid_i = 1'b0;
                    return;
                end
            end
            if (gap && k != len-1) begin
                in_valid_i = 1'b0; ifmap_i = 8'sd99;
                @(posedge clk); #1;
            end
        end
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("first_out_latency", int'(out_valid_o), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 || exp_done) begin
            @(posedge clk); #1;
            if (out_valid_o && out_idx_o == 2'd3) start_i = 1'b0;
            n++;
            if (n > 200) begin
                chk("drain_timeout", q.size(), 0);
                q.delete();
                exp_done = 1'b0;
                return;
            end
        end
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_t1();
        xs[0] = 8'sd1; xs[1] = 8'sd2; xs[2] = 8'sd3;
        for (int k = 0; k < 3; k++) ws[k] = pack4(1, 2, 3, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_in_ready", int'(in_ready_o), 0);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_data", int'(out_data_o), 0);
        chk("rst_out_idx", int'(out_idx_o), 0);
        chk("rst_done", int'(done_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_busy", int'(busy_o), 0);
        chk("idle_in_ready", int'(in_ready_o), 0);
        @(posedge clk); #1;

        // Basic: 1*k+2*k+3*k -> 6,12,18,24
        load_t1();
        expect4(6, 12, 18, 24);
        do_start(3, 0, 0, 0);
        feed(3, 0);
        wait_done();

        // Reset asserted mid-accumulation
        load_t1();
        do_start(3, 0, 0, 0);
        ifmap_i = xs[0]; weight_i = ws[0]; in_valid_i = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid_i = 1'b0;
        #1;
        chk("midrst_busy_async", int'(busy_o), 0);
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready_o), 0);
        chk("midrst_out_valid", int'(out_valid_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Rounding, then with ReLU
        xs[0] = 8'sd5; ws[0] = pack4(3, -3, 1, -1);
        expect4(8, -7, 3, -2);
        do_start(1, 1, 0, 0);
        feed(1, 0);
        wait_done();
        expect4(8, 0, 3, 0);
        do_start(1, 1, 1, 0);
        feed(1, 0);
        wait_done();

        // Saturation
        for (int k = 0; k < 4; k++) begin xs[k] = 8'sd127; ws[k] = pack4(127, -128, 1, -1); end
        expect4(127, -128, 127, -128);
        do_start(4, 0, 0, 0);
        feed(4, 0);
        wait_done();

        // Backpressure with gapped input, shift=2
        xs[0] = 8'sd2;  ws[0] = pack4(1, 2, 3, 4);
        xs[1] = -8'sd3; ws[1] = pack4(5, -1, 0, 2);
        xs[2] = 8'sd4;  ws[2] = pack4(-2, 3, 1, -7);
        xs[3] = -8'sd1; ws[3] = pack4(10, 0, -5, 1);
        expect4(-8, 5, 4, -7);
        rdy_toggle = 1'b1;
        do_start(4, 2, 0, 0);
        feed(4, 1);
        wait_done();
        rdy_toggle = 1'b0;
        @(posedge clk); #1;

        // start_i held through ACC and DRAIN
        load_t1();
        expect4(6, 12, 18, 24);
        do_start(3, 0, 0, 1);
        feed(3, 0);
        wait_done();

        // Zero-length vector with in_valid_i held high
        expect4(0, 0, 0, 0);
        in_valid_i = 1'b1; ifmap_i = 8'sd5; weight_i = pack4(1, 1, 1, 1);
        do_start(0, 3, 1, 0);
        @(negedge clk);
        chk("len0_valid_cycle1", int'(out_valid_o), 0);
        @(negedge clk);
        chk("len0_valid_cycle2", int'(out_valid_o), 1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        wait_done();

        // Back-to-back start on the done cycle
        xs[0] = 8'sd5; ws[0] = pack4(3, -3, 1, -1);
        expect4(8, -7, 3, -2);
        do_start(1, 1, 0, 0);
        feed(1, 0);
        n = 0;
        while (!done_o && n < 50) begin @(negedge clk); n++; end
        chk("b2b_done_seen", int'(done_o), 1);
        xs[0] = 8'sd1; ws[0] = pack4(1, 2, 3, 4);
        expect4(1, 2, 3, 4);
        do_start(1, 0, 0, 0);
        feed(1, 0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
